// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for TinyCPU: owns the PC and IR, handles HALT/JMP/JZ
// itself and hands all other opcodes to the datapath. Optional feature macro: SINGLE_STEP_EN.
module instr_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] OP_HALT  = 4'hF,
    parameter logic [3:0] OP_JMP   = 4'hE,
    parameter logic [3:0] OP_JZ    = 4'hD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [11:0] imem_rdata,
    input  logic        imem_ack,
    output logic [3:0]  opcode,
    output logic [7:0]  operand,
    output logic        exec_valid,
    input  logic        exec_done,
    input  logic        acc_zero,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4,
        ST_PAUSE  = 3'd5
    } state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t ST_AFTER = ST_PAUSE;
`else
    localparam state_t ST_AFTER = ST_FETCH;
`endif

    state_t      state_r, state_next_s;
    logic [7:0]  pc_r, pc_next_s;
    logic [11:0] ir_r;
    logic        ir_load_s;
    logic        imem_req_r, exec_valid_r, busy_r, halted_r;

    // Next-state, next-PC and IR-load decode
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        ir_load_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                    pc_next_s    = RESET_PC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_load_s    = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (ir_r[11:8] == OP_HALT) begin
                    state_next_s = ST_HALT;
                end else if (ir_r[11:8] == OP_JMP) begin
                    pc_next_s    = ir_r[7:0];
                    state_next_s = ST_AFTER;
                end else if (ir_r[11:8] == OP_JZ) begin
                    pc_next_s    = acc_zero ? ir_r[7:0] : (pc_r + 8'd1);
                    state_next_s = ST_AFTER;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    pc_next_s    = pc_r + 8'd1;
                    state_next_s = ST_AFTER;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                    pc_next_s    = RESET_PC;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
`ifdef SINGLE_STEP_EN
            ST_PAUSE: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                    pc_next_s    = RESET_PC;
                end else if (step) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
                pc_next_s    = RESET_PC;
            end
        endcase
    end

    // State, PC, IR and output flags; flags follow the next state so they are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            ir_r         <= 12'h000;
            imem_req_r   <= 1'b0;
            exec_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            pc_r         <= pc_next_s;
            ir_r         <= ir_load_s ? imem_rdata : ir_r;
            imem_req_r   <= (state_next_s == ST_FETCH);
            exec_valid_r <= (state_next_s == ST_EXEC);
            busy_r       <= (state_next_s == ST_FETCH) || (state_next_s == ST_DECODE) ||
                            (state_next_s == ST_EXEC);
            halted_r     <= (state_next_s == ST_HALT);
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign opcode     = ir_r[11:8];
    assign operand    = ir_r[7:0];
    assign exec_valid = exec_valid_r;
    assign busy       = busy_r;
    assign halted     = halted_r;

endmodule
